// File: rtl/eval_host_pkg.sv
// Shared widths and FSM state type for the evaluation-core host sequencer.
package eval_host_pkg;
  localparam int BOARD_W = 256;
  localparam int WORD_W  = 32;
  localparam int N_WORDS = 8;
  localparam int ADDR_W  = 3;
  localparam int SCORE_W = 15;

  typedef enum logic [2:0] {
    IDLE, LOAD, SIDE, START, WAIT, CLEAR, RESP
  } state_t;
endpackage

// File: rtl/eval_host_wdog.sv
// Run watchdog: 16-bit clear/enable counter with a registered expiry flag.
module eval_host_wdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_cnt;
  logic        r_expire;

  // Expiry is registered, so it is seen the cycle after the count reaches LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (i_clr) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 16'd1;
      if (r_cnt == LAST) r_expire <= 1'b1;
    end
  end

  assign o_expire = r_expire;
endmodule

// File: rtl/eval_host_seq.sv
// Host sequencer: loads a board into the eval core, programs side/start,
// waits for finished (or watchdog) and returns the score over valid/ready.
module eval_host_seq
  import eval_host_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BOARD_W-1:0]   board_in,
  input  logic                 side_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SCORE_W-1:0]   res_score,
  output logic                 res_timeout,
  output logic                 res_err,
  output logic                 reg_data_in,
  output logic                 start_wr_in,
  output logic                 side_wr_in,
  input  logic                 start_axi_out,
  input  logic                 side_axi_out,
  input  logic [SCORE_W-1:0]   result_axi_out,
  input  logic                 finished_axi_out,
  output logic [WORD_W-1:0]    mem_data_in,
  output logic                 mem_wr_in,
  output logic [ADDR_W-1:0]    mem_wr_addr_in
);
  state_t               r_state;
  logic                 r_alive;
  logic [BOARD_W-1:0]   r_board;
  logic                 r_side;
  logic [ADDR_W-1:0]    r_k;
  logic [SCORE_W-1:0]   r_score;
  logic                 r_to;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_expire;
  logic                 w_unused_start;

  assign w_unused_start = start_axi_out;
  assign w_accept       = req_valid && req_ready;

  eval_host_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept),
    .i_en     (r_state == WAIT),
    .o_expire (w_expire)
  );

  // Holds req_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_alive <= 1'b0;
    else      r_alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_board <= '0;
      r_side  <= 1'b0;
      r_k     <= '0;
      r_score <= '0;
      r_to    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_board <= board_in;
          r_side  <= side_in;
          r_k     <= '0;
          r_to    <= 1'b0;
          r_err   <= 1'b0;
          r_state <= LOAD;
        end
        LOAD: begin
          r_k <= r_k + 1'b1;
          if (r_k == ADDR_W'(N_WORDS - 1)) r_state <= SIDE;
        end
        SIDE:  r_state <= START;
        START: begin
          if (side_axi_out != r_side) r_err <= 1'b1;
          r_state <= WAIT;
        end
        // finished takes priority over a simultaneous watchdog expiry
        WAIT: if (finished_axi_out) begin
          r_score <= result_axi_out;
          r_state <= CLEAR;
        end else if (w_expire) begin
          r_to    <= 1'b1;
          r_score <= '0;
          r_state <= CLEAR;
        end
        CLEAR: r_state <= RESP;
        RESP: if (res_ready) begin
          r_to    <= 1'b0;
          r_err   <= 1'b0;
          r_score <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready      = r_alive && (r_state == IDLE);
  assign mem_wr_in      = (r_state == LOAD);
  assign mem_wr_addr_in = mem_wr_in ? r_k : '0;
  assign mem_data_in    = mem_wr_in ? r_board[{r_k, 5'b0} +: WORD_W] : '0;
  assign side_wr_in     = (r_state == SIDE);
  assign start_wr_in    = (r_state == START) || (r_state == CLEAR);
  assign reg_data_in    = ((r_state == SIDE) && r_side) || (r_state == START);
  assign res_valid      = (r_state == RESP);
  assign res_score      = r_score;
  assign res_timeout    = r_to;
  assign res_err        = r_err;
endmodule
